// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and forwarding controller for the 5-stage MIPS pipeline.
//
// Purpose:
//   Detects load-use hazards and HI/LO (mult/div) occupancy, stalling PC and
//   IF/ID and bubbling issue-execute when decode must wait.
//   Flushes IF/ID and issue-execute on a taken branch or jump resolved in EX.
//   Produces the EX operand forwarding selects (MEM over WB, never $0).
//   All control outputs are combinational; the mult/div busy counter is the
//   only pipeline-visible state.
//
// Ports:
//   clk, reset                 pipeline clock, synchronous active-high reset
//   rs_id_i, rt_id_i,
//   use_rs_id_i, use_rt_id_i   decode operands and whether they are read
//   md_use_id_i                decode instruction needs the HI/LO unit
//   valid_ex_i, rs_ex_i, rt_ex_i, dst_ex_i, reg_wr_ex_i, mem_to_reg_ex_i,
//   md_start_ex_i, branch_taken_ex_i, jump_ex_i
//                              EX-stage instruction description
//   dst_mem_i, reg_wr_mem_i    MEM-stage writeback target
//   dst_wb_i, reg_wr_wb_i      WB-stage writeback target
//   stall_pc_o, stall_id_o     hold PC / IF/ID
//   clr_id_o, clr_ex_o         flush IF/ID / issue-execute
//   fwd_a_o, fwd_b_o           operand select: 00 regfile, 01 WB, 10 MEM
//   md_busy_o                  HI/LO unit occupied
//
// Optional build macro HAZARD_STATS_EN adds three saturating 32-bit counters:
//   stall_cnt_o     cycles with stall_id_o high
//   flush_cnt_o     cycles with a branch/jump flush
//   md_stall_cnt_o  stall cycles caused by the busy HI/LO unit

module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_id_i,
    input  logic [REG_W-1:0] rt_id_i,
    input  logic             use_rs_id_i,
    input  logic             use_rt_id_i,
    input  logic             md_use_id_i,
    input  logic             valid_ex_i,
    input  logic [REG_W-1:0] rs_ex_i,
    input  logic [REG_W-1:0] rt_ex_i,
    input  logic [REG_W-1:0] dst_ex_i,
    input  logic             reg_wr_ex_i,
    input  logic             mem_to_reg_ex_i,
    input  logic             md_start_ex_i,
    input  logic             branch_taken_ex_i,
    input  logic             jump_ex_i,
    input  logic [REG_W-1:0] dst_mem_i,
    input  logic             reg_wr_mem_i,
    input  logic [REG_W-1:0] dst_wb_i,
    input  logic             reg_wr_wb_i,
    output logic             stall_pc_o,
    output logic             stall_id_o,
    output logic             clr_id_o,
    output logic             clr_ex_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             md_busy_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      flush_cnt_o,
    output logic [31:0]      md_stall_cnt_o
`endif
);

    // Counter is loaded with LATENCY-1 because the start cycle itself is the
    // first occupied EX cycle.
    localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 1);

    logic [5:0] md_cnt_q, md_cnt_d;

    logic load_use;
    logic md_busy;
    logic md_stall;
    logic flush;
    logic stall;

    always_comb begin
        load_use = valid_ex_i && mem_to_reg_ex_i && reg_wr_ex_i && (dst_ex_i != '0) &&
                   ((use_rs_id_i && (dst_ex_i == rs_id_i)) ||
                    (use_rt_id_i && (dst_ex_i == rt_id_i)));
        md_busy  = (md_cnt_q != 6'd0);
        md_stall = md_busy && md_use_id_i;
        flush    = valid_ex_i && (branch_taken_ex_i || jump_ex_i);
        // A flush discards the decode instruction, so any stall it wanted is moot.
        stall    = (load_use || md_stall) && !flush;
    end

    // Busy counter: a squashed start (flush) never occupies the unit; a forced
    // start while busy simply reloads.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_ex_i && valid_ex_i && !flush) begin
            md_cnt_d = MD_RELOAD;
        end else if (md_cnt_q != 6'd0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= 6'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // Forwarding select per EX source operand: index 0 is rs, 1 is rt.
    logic [REG_W-1:0] src_ex  [2];
    logic [1:0]       fwd_sel [2];

    assign src_ex[0] = rs_ex_i;
    assign src_ex[1] = rt_ex_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        always_comb begin
            fwd_sel[gi] = 2'b00;
            if (reg_wr_mem_i && (dst_mem_i != '0) && (dst_mem_i == src_ex[gi])) begin
                fwd_sel[gi] = 2'b10;
            end else if (reg_wr_wb_i && (dst_wb_i != '0) && (dst_wb_i == src_ex[gi])) begin
                fwd_sel[gi] = 2'b01;
            end
        end
    end

    // During reset both pipeline registers are held clear and nothing stalls.
    always_comb begin
        stall_pc_o = 1'b0;
        stall_id_o = 1'b0;
        clr_id_o   = 1'b1;
        clr_ex_o   = 1'b1;
        fwd_a_o    = 2'b00;
        fwd_b_o    = 2'b00;
        md_busy_o  = 1'b0;
        if (!reset) begin
            stall_pc_o = stall;
            stall_id_o = stall;
            clr_id_o   = flush;
            clr_ex_o   = flush || stall;
            fwd_a_o    = fwd_sel[0];
            fwd_b_o    = fwd_sel[1];
            md_busy_o  = md_busy;
        end
    end

`ifdef HAZARD_STATS_EN
    // Event index: 0 stall, 1 flush, 2 busy-caused stall.
    logic [2:0]  stat_evt;
    logic [31:0] stat_q [3];
    logic [31:0] stat_d [3];

    assign stat_evt[0] = stall;
    assign stat_evt[1] = flush;
    assign stat_evt[2] = md_stall && !flush;

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        always_comb begin
            stat_d[gi] = stat_q[gi];
            if (stat_evt[gi] && (stat_q[gi] != 32'hFFFF_FFFF)) begin
                stat_d[gi] = stat_q[gi] + 32'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stat_q[gi] <= 32'd0;
            end else begin
                stat_q[gi] <= stat_d[gi];
            end
        end
    end

    assign stall_cnt_o    = stat_q[0];
    assign flush_cnt_o    = stat_q[1];
    assign md_stall_cnt_o = stat_q[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MD_LATENCY=4).
// Control vector order in comparisons: {stall_pc, stall_id, clr_id, clr_ex}.

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_id_i, rt_id_i;
    logic       use_rs_id_i, use_rt_id_i, md_use_id_i;
    logic       valid_ex_i;
    logic [4:0] rs_ex_i, rt_ex_i, dst_ex_i;
    logic       reg_wr_ex_i, mem_to_reg_ex_i, md_start_ex_i;
    logic       branch_taken_ex_i, jump_ex_i;
    logic [4:0] dst_mem_i, dst_wb_i;
    logic       reg_wr_mem_i, reg_wr_wb_i;
    logic       stall_pc_o, stall_id_o, clr_id_o, clr_ex_o;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic       md_busy_o;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_o, flush_cnt_o, md_stall_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4), .REG_W(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .rs_id_i           (rs_id_i),
        .rt_id_i           (rt_id_i),
        .use_rs_id_i       (use_rs_id_i),
        .use_rt_id_i       (use_rt_id_i),
        .md_use_id_i       (md_use_id_i),
        .valid_ex_i        (valid_ex_i),
        .rs_ex_i           (rs_ex_i),
        .rt_ex_i           (rt_ex_i),
        .dst_ex_i          (dst_ex_i),
        .reg_wr_ex_i       (reg_wr_ex_i),
        .mem_to_reg_ex_i   (mem_to_reg_ex_i),
        .md_start_ex_i     (md_start_ex_i),
        .branch_taken_ex_i (branch_taken_ex_i),
        .jump_ex_i         (jump_ex_i),
        .dst_mem_i         (dst_mem_i),
        .reg_wr_mem_i      (reg_wr_mem_i),
        .dst_wb_i          (dst_wb_i),
        .reg_wr_wb_i       (reg_wr_wb_i),
        .stall_pc_o        (stall_pc_o),
        .stall_id_o        (stall_id_o),
        .clr_id_o          (clr_id_o),
        .clr_ex_o          (clr_ex_o),
        .fwd_a_o           (fwd_a_o),
        .fwd_b_o           (fwd_b_o),
        .md_busy_o         (md_busy_o)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o),
        .md_stall_cnt_o    (md_stall_cnt_o)
`endif
    );

    task automatic idle_inputs();
        rs_id_i = 5'd0; rt_id_i = 5'd0;
        use_rs_id_i = 1'b0; use_rt_id_i = 1'b0; md_use_id_i = 1'b0;
        valid_ex_i = 1'b0; rs_ex_i = 5'd0; rt_ex_i = 5'd0; dst_ex_i = 5'd0;
        reg_wr_ex_i = 1'b0; mem_to_reg_ex_i = 1'b0; md_start_ex_i = 1'b0;
        branch_taken_ex_i = 1'b0; jump_ex_i = 1'b0;
        dst_mem_i = 5'd0; reg_wr_mem_i = 1'b0; dst_wb_i = 5'd0; reg_wr_wb_i = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load_use(input logic [4:0] dst);
        valid_ex_i = 1'b1; mem_to_reg_ex_i = 1'b1; reg_wr_ex_i = 1'b1; dst_ex_i = dst;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        // Hazard and forwarding patterns present: reset must still dominate.
        drive_load_use(5'd5); use_rs_id_i = 1'b1; rs_id_i = 5'd5;
        rs_ex_i = 5'd6; dst_mem_i = 5'd6; reg_wr_mem_i = 1'b1;
        #2;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_id_o, clr_ex_o} !== 4'b0011) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 0011", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
        end
        tests++;
        if ({fwd_a_o, fwd_b_o, md_busy_o} !== 5'b00000) begin
            fails++; $display("FAIL reset_fwd_busy: got %b expected 00000", {fwd_a_o, fwd_b_o, md_busy_o});
        end
        $display("[TB] reset: ctrl=%b fwd_a=%b busy=%b", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o}, fwd_a_o, md_busy_o);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_id_o, clr_ex_o, md_busy_o} !== 5'b00000) begin
            fails++; $display("FAIL post_reset: got %b expected 00000", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o, md_busy_o});
        end
    endtask

    task automatic test_load_use();
        // rs match: one bubble.
        next_cycle(); idle_inputs();
        drive_load_use(5'd5); use_rs_id_i = 1'b1; rs_id_i = 5'd5;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_id_o, clr_ex_o} !== 4'b1101) begin
            fails++; $display("FAIL load_use_rs: got %b expected 1101", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
        end
        $display("[TB] load_use rs=5: ctrl=%b", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
        // Next cycle the bubble sits in EX; the held instruction proceeds.
        next_cycle(); idle_inputs(); use_rs_id_i = 1'b1; rs_id_i = 5'd5;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_id_o, clr_ex_o} !== 4'b0000) begin
            fails++; $display("FAIL load_use_release: got %b expected 0000", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
        end
        // rt match.
        next_cycle(); idle_inputs();
        drive_load_use(5'd7); use_rt_id_i = 1'b1; rt_id_i = 5'd7;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_ex_o} !== 3'b111) begin
            fails++; $display("FAIL load_use_rt: got %b expected 111", {stall_pc_o, stall_id_o, clr_ex_o});
        end
        // Same register but not read by decode: no stall.
        use_rt_id_i = 1'b0;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_ex_o} !== 3'b000) begin
            fails++; $display("FAIL load_use_unused: got %b expected 000", {stall_pc_o, stall_id_o, clr_ex_o});
        end
        // Load to $0 never stalls.
        drive_load_use(5'd0); use_rs_id_i = 1'b1; rs_id_i = 5'd0;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_ex_o} !== 3'b000) begin
            fails++; $display("FAIL load_use_r0: got %b expected 000", {stall_pc_o, stall_id_o, clr_ex_o});
        end
        // Non-load writer does not stall (forwarding covers it).
        drive_load_use(5'd9); mem_to_reg_ex_i = 1'b0; rs_id_i = 5'd9;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_ex_o} !== 3'b000) begin
            fails++; $display("FAIL load_use_alu: got %b expected 000", {stall_pc_o, stall_id_o, clr_ex_o});
        end
    endtask

    task automatic test_forwarding();
        next_cycle(); idle_inputs();
        rs_ex_i = 5'd8; rt_ex_i = 5'd3;
        dst_mem_i = 5'd8; dst_wb_i = 5'd8; reg_wr_mem_i = 1'b1; reg_wr_wb_i = 1'b1;
        #1;
        tests++;
        if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin
            fails++; $display("FAIL fwd_mem_prio: got %b expected 1000", {fwd_a_o, fwd_b_o});
        end
        $display("[TB] fwd both=8: fwd_a=%b fwd_b=%b", fwd_a_o, fwd_b_o);
        reg_wr_mem_i = 1'b0;
        #1;
        tests++;
        if (fwd_a_o !== 2'b01) begin
            fails++; $display("FAIL fwd_wb: got %b expected 01", fwd_a_o);
        end
        reg_wr_mem_i = 1'b1; rs_ex_i = 5'd0; rt_ex_i = 5'd0; dst_mem_i = 5'd0; dst_wb_i = 5'd0;
        #1;
        tests++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin
            fails++; $display("FAIL fwd_r0: got %b expected 0000", {fwd_a_o, fwd_b_o});
        end
        // rt path: MEM holds 3, WB holds 4; rs=4 takes WB, rt=3 takes MEM.
        rs_ex_i = 5'd4; rt_ex_i = 5'd3; dst_mem_i = 5'd3; dst_wb_i = 5'd4;
        #1;
        tests++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0110) begin
            fails++; $display("FAIL fwd_split: got %b expected 0110", {fwd_a_o, fwd_b_o});
        end
    endtask

    task automatic test_md_busy();
        int busy_cycles;
        busy_cycles = 0;
        next_cycle(); idle_inputs();
        valid_ex_i = 1'b1; md_start_ex_i = 1'b1;
        #1;
        tests++;
        if ({md_busy_o, stall_id_o} !== 2'b00) begin
            fails++; $display("FAIL md_start_cycle: got %b expected 00", {md_busy_o, stall_id_o});
        end
        // mfhi held in decode while the unit is occupied.
        next_cycle(); idle_inputs(); md_use_id_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if ({md_busy_o, stall_pc_o, stall_id_o, clr_id_o, clr_ex_o} !== 5'b11101) begin
                fails++; $display("FAIL md_busy_stall[%0d]: got %b expected 11101", k, {md_busy_o, stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
            end
            if (md_busy_o === 1'b1) busy_cycles++;
            $display("[TB] md cycle %0d: busy=%b stall=%b", k, md_busy_o, stall_id_o);
            next_cycle();
        end
        #1;
        tests++;
        if ({md_busy_o, stall_id_o, clr_ex_o} !== 3'b000) begin
            fails++; $display("FAIL md_issue: got %b expected 000", {md_busy_o, stall_id_o, clr_ex_o});
        end
        tests++;
        if (busy_cycles != 3) begin
            fails++; $display("FAIL md_busy_count: got %0d expected 3", busy_cycles);
        end
        // A mult/div squashed by a flush never occupies the unit.
        next_cycle(); idle_inputs();
        valid_ex_i = 1'b1; md_start_ex_i = 1'b1; branch_taken_ex_i = 1'b1;
        next_cycle(); idle_inputs(); md_use_id_i = 1'b1;
        #1;
        tests++;
        if ({md_busy_o, stall_id_o} !== 2'b00) begin
            fails++; $display("FAIL md_flushed_start: got %b expected 00", {md_busy_o, stall_id_o});
        end
    endtask

    task automatic test_flush_vs_stall();
        next_cycle(); idle_inputs();
        drive_load_use(5'd5); use_rs_id_i = 1'b1; rs_id_i = 5'd5; branch_taken_ex_i = 1'b1;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_id_o, clr_ex_o} !== 4'b0011) begin
            fails++; $display("FAIL flush_over_stall: got %b expected 0011", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
        end
        $display("[TB] flush+load_use: ctrl=%b", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
        next_cycle(); idle_inputs();
        valid_ex_i = 1'b1; jump_ex_i = 1'b1;
        #1;
        tests++;
        if ({stall_pc_o, stall_id_o, clr_id_o, clr_ex_o} !== 4'b0011) begin
            fails++; $display("FAIL jump_flush: got %b expected 0011", {stall_pc_o, stall_id_o, clr_id_o, clr_ex_o});
        end
        // An invalid EX slot cannot redirect.
        valid_ex_i = 1'b0;
        #1;
        tests++;
        if ({clr_id_o, clr_ex_o} !== 2'b00) begin
            fails++; $display("FAIL invalid_flush: got %b expected 00", {clr_id_o, clr_ex_o});
        end
    endtask

    task automatic test_reset_mid_op();
        next_cycle(); idle_inputs();
        valid_ex_i = 1'b1; md_start_ex_i = 1'b1;
        next_cycle(); idle_inputs();
        next_cycle();
        // Counter would be 2 here; reset lands now.
        reset = 1'b1;
        #1;
        tests++;
        if ({clr_id_o, clr_ex_o, md_busy_o} !== 3'b110) begin
            fails++; $display("FAIL reset_mid_ctrl: got %b expected 110", {clr_id_o, clr_ex_o, md_busy_o});
        end
        next_cycle();
        reset = 1'b0; md_use_id_i = 1'b1;
        #1;
        tests++;
        if ({md_busy_o, stall_id_o} !== 2'b00) begin
            fails++; $display("FAIL reset_mid_busy: got %b expected 00", {md_busy_o, stall_id_o});
        end
        $display("[TB] reset mid mult: busy=%b", md_busy_o);
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        next_cycle(); idle_inputs(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle_inputs(); drive_load_use(5'd5); use_rs_id_i = 1'b1; rs_id_i = 5'd5;
            next_cycle(); idle_inputs();
            next_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            idle_inputs(); valid_ex_i = 1'b1; branch_taken_ex_i = 1'b1;
            next_cycle(); idle_inputs();
            next_cycle();
        end
        tests++;
        if (stall_cnt_o !== 32'd3) begin
            fails++; $display("FAIL stats_stall: got %0d expected 3", stall_cnt_o);
        end
        tests++;
        if (flush_cnt_o !== 32'd2) begin
            fails++; $display("FAIL stats_flush: got %0d expected 2", flush_cnt_o);
        end
        tests++;
        if (md_stall_cnt_o !== 32'd0) begin
            fails++; $display("FAIL stats_md: got %0d expected 0", md_stall_cnt_o);
        end
        $display("[TB] stats: stall=%0d flush=%0d md=%0d", stall_cnt_o, flush_cnt_o, md_stall_cnt_o);
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_md_busy();
        test_flush_vs_stall();
        test_reset_mid_op();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
